// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK controller that owns the PC and decodes 16-bit instructions.
// Optional STEP_DEBUG_EN adds a `step` input that gates each fetch on a rising edge of step.
module control_unit #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
`ifdef STEP_DEBUG_EN
  input  logic                step,
`endif
  output logic                instr_req,
  output logic [PC_WIDTH-1:0] instr_addr,
  input  logic                instr_valid,
  input  logic [15:0]         instr_data,
  output logic                rf_write,
  output logic                mem_write,
  output logic                imm_sel,
  output logic [2:0]          rs_addr,
  output logic [2:0]          rt_addr,
  output logic [2:0]          rd_addr,
  output logic [15:0]         imm_data,
  output logic [3:0]          alu_sel,
  input  logic                zero_flag,
  input  logic                pos_flag,
  output logic                halted,
  output logic                illegal_op
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_MOVI = 5'b10110;
  localparam logic [4:0] OP_ST   = 5'b10111;
  localparam logic [4:0] OP_BZ   = 5'b11000;
  localparam logic [4:0] OP_BP   = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11111;

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

  function automatic logic is_branch(input logic [4:0] op);
    return (op == OP_BZ) || (op == OP_BP);
  endfunction

  function automatic logic is_known(input logic [4:0] op);
    return is_alu_op(op) || is_branch(op) || (op == OP_NOP) ||
           (op == OP_MOVI) || (op == OP_ST) || (op == OP_HALT);
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD:       return 4'b0000;
      OP_SUB:       return 4'b0001;
      OP_AND:       return 4'b0010;
      OP_OR:        return 4'b0011;
      OP_XOR:       return 4'b0100;
      OP_MOVI:      return 4'b1011;
      OP_BZ, OP_BP: return 4'b1010;
      default:      return 4'b0000;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [4:0]          op_q, op_d;
  logic                take_q, take_d;
  logic                instr_req_q, instr_req_d;
  logic                rf_write_q, rf_write_d;
  logic                mem_write_q, mem_write_d;
  logic                imm_sel_q, imm_sel_d;
  logic [2:0]          rs_addr_q, rs_addr_d;
  logic [2:0]          rt_addr_q, rt_addr_d;
  logic [2:0]          rd_addr_q, rd_addr_d;
  logic [15:0]         imm_data_q, imm_data_d;
  logic [3:0]          alu_sel_q, alu_sel_d;
  logic                halted_q, halted_d;
  logic                illegal_op_q, illegal_op_d;
  logic                fetch_go;

`ifdef STEP_DEBUG_EN
  // One pending step edge is remembered so a pulse during an instruction releases the next fetch.
  logic step_prev_q;
  logic step_pend_q, step_pend_d;
  logic step_rise;

  assign step_rise = step & ~step_prev_q;
  assign fetch_go  = step_pend_q | step_rise;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step_prev_q <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      step_prev_q <= step;
      step_pend_q <= step_pend_d;
    end
  end
`else
  assign fetch_go = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    op_d         = op_q;
    take_d       = take_q;
    instr_req_d  = instr_req_q;
    rf_write_d   = 1'b0;
    mem_write_d  = 1'b0;
    imm_sel_d    = imm_sel_q;
    rs_addr_d    = rs_addr_q;
    rt_addr_d    = rt_addr_q;
    rd_addr_d    = rd_addr_q;
    imm_data_d   = imm_data_q;
    alu_sel_d    = alu_sel_q;
    halted_d     = halted_q;
    illegal_op_d = 1'b0;
`ifdef STEP_DEBUG_EN
    step_pend_d  = step_pend_q | step_rise;
`endif
    case (state_q)
      S_FETCH: begin
        if (instr_req_q && instr_valid) begin
          state_d      = S_DECODE;
          instr_req_d  = 1'b0;
          op_d         = instr_data[15:11];
          rd_addr_d    = instr_data[10:8];
          rt_addr_d    = instr_data[4:2];
          rs_addr_d    = is_branch(instr_data[15:11]) ? instr_data[10:8] : instr_data[7:5];
          imm_data_d   = {8'h00, instr_data[7:0]};
          imm_sel_d    = (instr_data[15:11] == OP_MOVI);
          illegal_op_d = !is_known(instr_data[15:11]);
        end else if (!instr_req_q && fetch_go) begin
          instr_req_d = 1'b1;
`ifdef STEP_DEBUG_EN
          step_pend_d = 1'b0;
`endif
        end
      end
      S_DECODE: begin
        if (op_q == OP_HALT) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d   = S_EXECUTE;
          alu_sel_d = alu_code(op_q);
        end
      end
      S_EXECUTE: begin
        // Flags reflect the ALU result of this EXECUTE cycle and are captured as it ends.
        state_d     = S_WRITEBACK;
        rf_write_d  = is_alu_op(op_q) || (op_q == OP_MOVI);
        mem_write_d = (op_q == OP_ST);
        take_d      = ((op_q == OP_BZ) && zero_flag) || ((op_q == OP_BP) && pos_flag);
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
        pc_d    = take_q ? pc_q + PC_WIDTH'(signed'(imm_data_q[7:0]))
                         : pc_q + PC_WIDTH'(1);
        if (fetch_go) begin
          instr_req_d = 1'b1;
`ifdef STEP_DEBUG_EN
          step_pend_d = 1'b0;
`endif
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      op_q         <= '0;
      take_q       <= 1'b0;
      instr_req_q  <= 1'b0;
      rf_write_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      imm_sel_q    <= 1'b0;
      rs_addr_q    <= '0;
      rt_addr_q    <= '0;
      rd_addr_q    <= '0;
      imm_data_q   <= '0;
      alu_sel_q    <= '0;
      halted_q     <= 1'b0;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      op_q         <= op_d;
      take_q       <= take_d;
      instr_req_q  <= instr_req_d;
      rf_write_q   <= rf_write_d;
      mem_write_q  <= mem_write_d;
      imm_sel_q    <= imm_sel_d;
      rs_addr_q    <= rs_addr_d;
      rt_addr_q    <= rt_addr_d;
      rd_addr_q    <= rd_addr_d;
      imm_data_q   <= imm_data_d;
      alu_sel_q    <= alu_sel_d;
      halted_q     <= halted_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  assign instr_req  = instr_req_q;
  assign instr_addr = pc_q;
  assign rf_write   = rf_write_q;
  assign mem_write  = mem_write_q;
  assign imm_sel    = imm_sel_q;
  assign rs_addr    = rs_addr_q;
  assign rt_addr    = rt_addr_q;
  assign rd_addr    = rd_addr_q;
  assign imm_data   = imm_data_q;
  assign alu_sel    = alu_sel_q;
  assign halted     = halted_q;
  assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each scenario task drives instructions and checks the
// controller outputs against hand-computed values at the falling clock edge.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req;
  logic [7:0]  instr_addr;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_data = 16'h0000;
  logic        rf_write;
  logic        mem_write;
  logic        imm_sel;
  logic [2:0]  rs_addr;
  logic [2:0]  rt_addr;
  logic [2:0]  rd_addr;
  logic [15:0] imm_data;
  logic [3:0]  alu_sel;
  logic        zero_flag = 1'b0;
  logic        pos_flag = 1'b0;
  logic        halted;
  logic        illegal_op;
`ifdef STEP_DEBUG_EN
  logic        step = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clock       (clk),
    .reset       (rst_n),
`ifdef STEP_DEBUG_EN
    .step        (step),
`endif
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .rf_write    (rf_write),
    .mem_write   (mem_write),
    .imm_sel     (imm_sel),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rd_addr     (rd_addr),
    .imm_data    (imm_data),
    .alu_sel     (alu_sel),
    .zero_flag   (zero_flag),
    .pos_flag    (pos_flag),
    .halted      (halted),
    .illegal_op  (illegal_op)
  );

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) at falling edges for instr_req, then presents one word for one cycle.
  // Returns at the falling edge inside DECODE.
  task automatic fetch(input logic [15:0] word);
    int n = 0;
    while (instr_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (instr_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_wait instr_req=%b required 1", instr_req);
    end
    instr_valid = 1'b1;
    instr_data  = word;
    @(negedge clk);
    instr_valid = 1'b0;
    instr_data  = 16'h0000;
  endtask

  // From the DECODE falling edge, walks EXECUTE, WRITEBACK and the next FETCH, counting strobes.
  task automatic finish_instr(output int rf_n, output int mem_n);
    rf_n  = 0;
    mem_n = 0;
    repeat (3) begin
      @(negedge clk);
      rf_n  += int'(rf_write);
      mem_n += int'(mem_write);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (instr_req !== 1'b0 || rf_write !== 1'b0 || halted !== 1'b0 || instr_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs req=%b rf=%b halted=%b addr=%h required 0 0 0 00",
               instr_req, rf_write, halted, instr_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_req !== 1'b1 || instr_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_first_fetch req=%b addr=%h required 1 00", instr_req, instr_addr);
    end
  endtask

  task automatic test_movi();
    fetch(16'hB708);
    checks++;
    if (imm_sel !== 1'b1 || rd_addr !== 3'd7 || imm_data !== 16'h0008 || rf_write !== 1'b0) begin
      errors++;
      $display("FAIL movi_decode imm_sel=%b rd=%0d imm=%h rf=%b required 1 7 0008 0",
               imm_sel, rd_addr, imm_data, rf_write);
    end
    @(negedge clk);
    checks++;
    if (alu_sel !== 4'b1011 || rf_write !== 1'b0) begin
      errors++;
      $display("FAIL movi_execute alu=%b rf=%b required 1011 0", alu_sel, rf_write);
    end
    @(negedge clk);
    checks++;
    if (rf_write !== 1'b1 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL movi_writeback rf=%b mem=%b required 1 0", rf_write, mem_write);
    end
    @(negedge clk);
    checks++;
    if (rf_write !== 1'b0 || instr_addr !== 8'h01 || instr_req !== 1'b1) begin
      errors++;
      $display("FAIL movi_next rf=%b addr=%h req=%b required 0 01 1", rf_write, instr_addr, instr_req);
    end
  endtask

  task automatic test_add();
    int rf_n, mem_n;
    fetch(16'h0B28);
    checks++;
    if (rs_addr !== 3'd1 || rt_addr !== 3'd2 || rd_addr !== 3'd3 || imm_sel !== 1'b0) begin
      errors++;
      $display("FAIL add_decode rs=%0d rt=%0d rd=%0d imm_sel=%b required 1 2 3 0",
               rs_addr, rt_addr, rd_addr, imm_sel);
    end
    finish_instr(rf_n, mem_n);
    checks++;
    if (alu_sel !== 4'b0000 || rf_n != 1 || mem_n != 0 || instr_addr !== 8'h02) begin
      errors++;
      $display("FAIL add_result alu=%b rf_pulses=%0d mem_pulses=%0d addr=%h required 0000 1 0 02",
               alu_sel, rf_n, mem_n, instr_addr);
    end
  endtask

  task automatic test_branch();
    int rf_n, mem_n;
    repeat (3) begin
      fetch(16'h0000);
      finish_instr(rf_n, mem_n);
    end
    checks++;
    if (instr_addr !== 8'h05) begin
      errors++;
      $display("FAIL nop_advance addr=%h required 05", instr_addr);
    end
    zero_flag = 1'b1;
    fetch(16'hC4FE);
    checks++;
    if (rs_addr !== 3'd4 || imm_data !== 16'h00FE) begin
      errors++;
      $display("FAIL bz_decode rs=%0d imm=%h required 4 00FE", rs_addr, imm_data);
    end
    finish_instr(rf_n, mem_n);
    zero_flag = 1'b0;
    checks++;
    if (alu_sel !== 4'b1010 || rf_n != 0 || mem_n != 0 || instr_addr !== 8'h03) begin
      errors++;
      $display("FAIL bz_taken alu=%b rf=%0d mem=%0d addr=%h required 1010 0 0 03",
               alu_sel, rf_n, mem_n, instr_addr);
    end
    repeat (2) begin
      fetch(16'h0000);
      finish_instr(rf_n, mem_n);
    end
    fetch(16'hC4FE);
    finish_instr(rf_n, mem_n);
    checks++;
    if (rf_n != 0 || mem_n != 0 || instr_addr !== 8'h06) begin
      errors++;
      $display("FAIL bz_not_taken rf=%0d mem=%0d addr=%h required 0 0 06", rf_n, mem_n, instr_addr);
    end
  endtask

  task automatic test_illegal();
    int ill_n = 0;
    int rf_n = 0;
    int mem_n = 0;
    fetch(16'h5000);
    checks++;
    if (illegal_op !== 1'b1) begin
      errors++;
      $display("FAIL illegal_pulse illegal_op=%b required 1", illegal_op);
    end
    repeat (3) begin
      @(negedge clk);
      ill_n += int'(illegal_op);
      rf_n  += int'(rf_write);
      mem_n += int'(mem_write);
    end
    checks++;
    if (ill_n != 0 || rf_n != 0 || mem_n != 0 || instr_addr !== 8'h07) begin
      errors++;
      $display("FAIL illegal_after ill=%0d rf=%0d mem=%0d addr=%h required 0 0 0 07",
               ill_n, rf_n, mem_n, instr_addr);
    end
  endtask

  task automatic test_valid_stall();
    int rf_n, mem_n;
    int bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (instr_req !== 1'b1 || instr_addr !== 8'h07) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold bad_cycles=%0d required 0", bad);
    end
    fetch(16'h1234);
    checks++;
    if (rd_addr !== 3'd2 || rs_addr !== 3'd1 || rt_addr !== 3'd5 || instr_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_decode rd=%0d rs=%0d rt=%0d req=%b required 2 1 5 0",
               rd_addr, rs_addr, rt_addr, instr_req);
    end
    finish_instr(rf_n, mem_n);
    checks++;
    if (alu_sel !== 4'b0001 || rf_n != 1 || instr_addr !== 8'h08) begin
      errors++;
      $display("FAIL sub_result alu=%b rf=%0d addr=%h required 0001 1 08", alu_sel, rf_n, instr_addr);
    end
  endtask

  task automatic test_store();
    int rf_n, mem_n;
    fetch(16'hB8E4);
    checks++;
    if (rs_addr !== 3'd7 || rt_addr !== 3'd1 || imm_sel !== 1'b0) begin
      errors++;
      $display("FAIL st_decode rs=%0d rt=%0d imm_sel=%b required 7 1 0", rs_addr, rt_addr, imm_sel);
    end
    finish_instr(rf_n, mem_n);
    checks++;
    if (rf_n != 0 || mem_n != 1 || instr_addr !== 8'h09) begin
      errors++;
      $display("FAIL st_result rf=%0d mem=%0d addr=%h required 0 1 09", rf_n, mem_n, instr_addr);
    end
  endtask

  task automatic test_reset_in_execute();
    int rf_n = 0;
    fetch(16'h1234);
    @(negedge clk);
    checks++;
    if (alu_sel !== 4'b0001) begin
      errors++;
      $display("FAIL rie_execute alu=%b required 0001", alu_sel);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (instr_req !== 1'b0 || instr_addr !== 8'h00 || rs_addr !== 3'd0 || rt_addr !== 3'd0 ||
        rd_addr !== 3'd0 || imm_data !== 16'h0000 || alu_sel !== 4'b0000 || rf_write !== 1'b0 ||
        mem_write !== 1'b0 || imm_sel !== 1'b0 || halted !== 1'b0 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL rie_outputs req=%b addr=%h rs=%0d rt=%0d rd=%0d imm=%h alu=%b rf=%b required all 0",
               instr_req, instr_addr, rs_addr, rt_addr, rd_addr, imm_data, alu_sel, rf_write);
    end
    repeat (2) begin
      @(negedge clk);
      rf_n += int'(rf_write);
    end
    rst_n = 1'b1;
    @(negedge clk);
    rf_n += int'(rf_write);
    checks++;
    if (rf_n != 0 || instr_req !== 1'b1 || instr_addr !== 8'h00) begin
      errors++;
      $display("FAIL rie_restart rf=%0d req=%b addr=%h required 0 1 00", rf_n, instr_req, instr_addr);
    end
  endtask

  task automatic test_wrap();
    int rf_n, mem_n;
    pos_flag = 1'b1;
    fetch(16'hC9FE);
    checks++;
    if (rs_addr !== 3'd1) begin
      errors++;
      $display("FAIL bp_decode rs=%0d required 1", rs_addr);
    end
    finish_instr(rf_n, mem_n);
    pos_flag = 1'b0;
    checks++;
    if (instr_addr !== 8'hFE || rf_n != 0) begin
      errors++;
      $display("FAIL bp_wrap_down addr=%h rf=%0d required FE 0", instr_addr, rf_n);
    end
    repeat (2) begin
      fetch(16'h0000);
      finish_instr(rf_n, mem_n);
    end
    checks++;
    if (instr_addr !== 8'h00) begin
      errors++;
      $display("FAIL pc_wrap_up addr=%h required 00", instr_addr);
    end
    fetch(16'hC9FE);
    finish_instr(rf_n, mem_n);
    checks++;
    if (instr_addr !== 8'h01) begin
      errors++;
      $display("FAIL bp_not_taken addr=%h required 01", instr_addr);
    end
  endtask

  task automatic test_halt();
    int bad = 0;
    fetch(16'hF800);
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || instr_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_enter halted=%b req=%b required 1 0", halted, instr_req);
    end
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_req !== 1'b0 || halted !== 1'b1 || instr_addr !== 8'h01 || rf_write !== 1'b0) bad++;
    end
    instr_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_hold bad_cycles=%0d required 0", bad);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_addr !== 8'h00 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset addr=%h halted=%b required 00 0", instr_addr, halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_req !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_restart req=%b halted=%b required 1 0", instr_req, halted);
    end
  endtask

`ifdef STEP_DEBUG_EN
  task automatic test_step();
    int req_n = 0;
    int rf_n, mem_n;
    rst_n = 1'b0;
    step  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      req_n += int'(instr_req);
    end
    checks++;
    if (req_n != 0) begin
      errors++;
      $display("FAIL step_idle req_cycles=%0d required 0", req_n);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    fetch(16'h0000);
    finish_instr(rf_n, mem_n);
    req_n = 0;
    repeat (10) begin
      @(negedge clk);
      req_n += int'(instr_req);
    end
    checks++;
    if (req_n != 0 || instr_addr !== 8'h01) begin
      errors++;
      $display("FAIL step_single req_cycles=%0d addr=%h required 0 01", req_n, instr_addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_movi();
    test_add();
    test_branch();
    test_illegal();
    test_valid_stall();
    test_store();
    test_reset_in_execute();
    test_wrap();
    test_halt();
`ifdef STEP_DEBUG_EN
    test_step();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
